// File: rtl/proc_pkg.sv
// Shared definitions for the task processor: sequencer state encoding,
// opcodes and instruction field layout.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_IRMOV = 4'h1;

  localparam int ICODE_HI = 31;
  localparam int ICODE_LO = 28;
  localparam int IFUN_HI  = 27;
  localparam int IFUN_LO  = 24;
  localparam int RA_HI    = 23;
  localparam int RA_LO    = 21;
  localparam int RB_HI    = 20;
  localparam int RB_LO    = 18;
  localparam int RD_HI    = 17;
  localparam int RD_LO    = 15;
  localparam int VALC_HI  = 14;
  localparam int VALC_LO  = 0;
  localparam int VALC_W   = 15;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [2:0]        rd;
    logic [VALC_W-1:0] valc;
  } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction field split with halt/irmov classification;
// shared by the sequencer and the processor top debug outputs.
module instr_decode
  import proc_pkg::*;
#(
  parameter logic [3:0] OP_HALT  = proc_pkg::OP_HALT,
  parameter logic [3:0] OP_IRMOV = proc_pkg::OP_IRMOV
) (
  input  logic [31:0] i_instr,
  output instr_t      o_fields,
  output logic        o_is_halt,
  output logic        o_is_irmov
);

  assign o_fields.icode = i_instr[ICODE_HI:ICODE_LO];
  assign o_fields.ifun  = i_instr[IFUN_HI:IFUN_LO];
  assign o_fields.ra    = i_instr[RA_HI:RA_LO];
  assign o_fields.rb    = i_instr[RB_HI:RB_LO];
  assign o_fields.rd    = i_instr[RD_HI:RD_LO];
  assign o_fields.valc  = i_instr[VALC_HI:VALC_LO];

  // ifun is deliberately ignored: every HALT variant stops execution.
  assign o_is_halt  = (o_fields.icode == OP_HALT);
  assign o_is_irmov = (o_fields.icode == OP_IRMOV);

endmodule

// File: rtl/exec_sequencer.sv
// Run controller owning the instruction RAM port: loads a program from the
// host stream, then sequences FETCH/EXEC with run, single-step and halt.
module exec_sequencer
  import proc_pkg::*;
#(
  parameter int         ADDR_W   = 9,
  parameter int         DATA_W   = 32,
  parameter logic [3:0] OP_HALT  = proc_pkg::OP_HALT,
  parameter logic [3:0] OP_IRMOV = proc_pkg::OP_IRMOV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wEn,
  output logic [DATA_W-1:0] ram_wDat,
  output logic              ram_rEn,
  input  logic [DATA_W-1:0] ram_rDat,
  output logic              rf_wen,
  output logic [2:0]        rf_dst,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              halted,
  output logic              load_ovf,
  output logic [2:0]        state
);

  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   L_ZERO = {(ADDR_W+1){1'b0}};

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic              r_halted;
  logic              r_load_ovf;
  logic              r_single_step;

  instr_t            w_fields;
  logic              w_is_halt;
  logic              w_is_irmov;
  logic [ADDR_W:0]   w_pc_inc;
  logic              w_prog_empty;
  logic              w_load_end;

  instr_decode #(
    .OP_HALT  (OP_HALT),
    .OP_IRMOV (OP_IRMOV)
  ) u_decode (
    .i_instr    (ram_rDat[31:0]),
    .o_fields   (w_fields),
    .o_is_halt  (w_is_halt),
    .o_is_irmov (w_is_irmov)
  );

  // pc+1 is compared one bit wider so a full 2**ADDR_W program still ends cleanly.
  assign w_pc_inc     = {1'b0, r_pc} + {1'b0, A_ONE};
  assign w_prog_empty = (r_prog_len == L_ZERO);
  assign w_load_end   = load_last || (r_load_ptr == A_LAST);

  assign rf_dst   = w_fields.rd;
  assign rf_wdata = {{(DATA_W-VALC_W){1'b0}}, w_fields.valc};
  assign pc       = r_pc;
  assign prog_len = r_prog_len;
  assign halted   = r_halted;
  assign load_ovf = r_load_ovf;
  assign state    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    ram_addr    = r_pc;
    ram_wEn     = 1'b0;
    ram_wDat    = load_data;
    ram_rEn     = 1'b0;
    rf_wen      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_state_nxt = ST_LOAD;
        end else if ((start || step) && !w_prog_empty) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_addr    = r_load_ptr;
          ram_wEn     = 1'b1;
          w_state_nxt = w_load_end ? ST_IDLE : ST_LOAD;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_FETCH: begin
        ram_rEn     = 1'b1;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          rf_wen = w_is_irmov;
          if (w_pc_inc == r_prog_len) begin
            w_state_nxt = ST_HALT;
          end else if (r_single_step) begin
            w_state_nxt = ST_IDLE;
          end else if (!start) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = load_valid ? ST_LOAD : ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= A_ZERO;
      r_load_ptr    <= A_ZERO;
      r_prog_len    <= L_ZERO;
      r_halted      <= 1'b0;
      r_load_ovf    <= 1'b0;
      r_single_step <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          // step wins over start, so a combined request runs one instruction.
          if (!load_valid && step && !w_prog_empty) begin
            r_single_step <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (w_load_end) begin
              r_prog_len <= {1'b0, r_load_ptr} + {1'b0, A_ONE};
              r_pc       <= A_ZERO;
              r_load_ptr <= A_ZERO;
              r_halted   <= 1'b0;
              if (!load_last) begin
                r_load_ovf <= 1'b1;
              end
            end else begin
              r_load_ptr <= r_load_ptr + A_ONE;
            end
          end
        end
        ST_EXEC: begin
          r_single_step <= 1'b0;
          if (!w_is_halt) begin
            r_pc <= r_pc + A_ONE;
          end
          if (w_state_nxt == ST_HALT) begin
            r_halted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with a RAM and
// register-file model hanging off its ports.
module tb_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [8:0]  ram_addr;
  logic        ram_wEn;
  logic [31:0] ram_wDat;
  logic        ram_rEn;
  logic [31:0] ram_rDat;
  logic        rf_wen;
  logic [2:0]  rf_dst;
  logic [31:0] rf_wdata;
  logic [8:0]  pc;
  logic [9:0]  prog_len;
  logic        halted;
  logic        load_ovf;
  logic [2:0]  state;

  exec_sequencer dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .step(step),
    .ram_addr(ram_addr), .ram_wEn(ram_wEn), .ram_wDat(ram_wDat),
    .ram_rEn(ram_rEn), .ram_rDat(ram_rDat),
    .rf_wen(rf_wen), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .pc(pc), .prog_len(prog_len), .halted(halted), .load_ovf(load_ovf),
    .state(state)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:511];
  logic [31:0] rf_m [0:7] = '{default: 32'd0};

  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_wDat;
    if (ram_rEn) ram_rDat <= mem[ram_addr];
  end

  always @(posedge clock) begin
    if (rf_wen) rf_m[rf_dst] <= rf_wdata;
  end

  int          cyc = 0;
  int          wr_n = 0;
  int          ren_cnt = 0;
  int          viol = 0;
  logic [2:0]  wr_dst [0:31];
  logic [31:0] wr_dat [0:31];
  int          wr_cyc [0:31];

  always @(negedge clock) begin
    cyc++;
    if (!reset && rf_wen && wr_n < 32) begin
      wr_dst[wr_n] = rf_dst;
      wr_dat[wr_n] = rf_wdata;
      wr_cyc[wr_n] = cyc;
      wr_n++;
    end
    if (ram_rEn) ren_cnt++;
    if (ram_wEn && state != 3'd1) viol++;
    if (ram_rEn && state != 3'd2) viol++;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [31:0] prog_w [0:511];

  task automatic load_words(input int n, input bit use_last);
    bit accepted;
    int guard;
    for (int i = 0; i < n; i++) begin
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 8) begin
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = prog_w[i];
        load_last  = use_last && (i == n - 1);
        accepted   = load_ready;
        @(posedge clock);
        guard++;
      end
      if (!accepted) check_eq("load_accept_timeout", {63'd0, accepted}, 64'd1);
    end
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq(tag, {63'd0, halted}, 64'd1);
  endtask

  int base;
  int rbase;
  logic [8:0] exp_pc;
  logic [2:0] exp_st;
  int exp_w;

  initial begin
    // reset state
    #12;
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_pc", pc, 9'd0);
    check_eq("rst_prog_len", prog_len, 10'd0);
    check_eq("rst_flags", {halted, load_ovf, load_ready}, 3'b000);
    check_eq("rst_strobes", {rf_wen, ram_wEn, ram_rEn}, 3'b000);
    @(negedge clock);
    reset = 1'b0;

    // no program: start and step ignored
    start = 1'b1;
    step  = 1'b1;
    @(negedge clock);
    step = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("empty_state", state, 3'd0);
    check_eq("empty_ren", ren_cnt, 0);
    start = 1'b0;

    // program A: IRMOV r1,5 ; IRMOV r2,0x7FFF ; HALT (ifun=F)
    prog_w[0] = 32'h1000_8005;
    prog_w[1] = 32'h1001_7FFF;
    prog_w[2] = 32'h0F00_0000;
    load_words(3, 1'b1);
    check_eq("A_mem0", mem[0], 32'h1000_8005);
    check_eq("A_mem1", mem[1], 32'h1001_7FFF);
    check_eq("A_mem2", mem[2], 32'h0F00_0000);
    check_eq("A_prog_len", prog_len, 10'd3);
    check_eq("A_ovf", {63'd0, load_ovf}, 64'd0);
    check_eq("A_ready_low", {63'd0, load_ready}, 64'd0);

    // continuous run
    base = wr_n;
    rbase = ren_cnt;
    start = 1'b1;
    wait_halted("run_halted", 30);
    start = 1'b0;
    check_eq("run_nwr", wr_n - base, 2);
    check_eq("run_w0", {wr_dst[base], wr_dat[base]}, {3'd1, 32'h0000_0005});
    check_eq("run_w1", {wr_dst[base+1], wr_dat[base+1]}, {3'd2, 32'h0000_7FFF});
    check_eq("run_spacing", wr_cyc[base+1] - wr_cyc[base], 2);
    check_eq("run_rf1", rf_m[1], 32'h5);
    check_eq("run_rf2", rf_m[2], 32'h7FFF);
    check_eq("run_pc", pc, 9'd2);
    check_eq("run_state", state, 3'd4);
    check_eq("run_ren", ren_cnt - rbase, 3);
    step = 1'b1;
    @(negedge clock);
    step  = 1'b0;
    start = 1'b1;
    repeat (8) @(negedge clock);
    start = 1'b0;
    check_eq("halt_sticky", state, 3'd4);
    check_eq("halt_no_ren", ren_cnt - rbase, 3);

    // reload A from HALT, then single-step
    load_words(3, 1'b1);
    check_eq("reload_halted", {63'd0, halted}, 64'd0);
    check_eq("reload_pc", pc, 9'd0);
    check_eq("reload_state", state, 3'd0);
    base = wr_n;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      repeat (4) @(negedge clock);
      exp_w  = (k < 2) ? k + 1 : 2;
      exp_pc = (k == 0) ? 9'd1 : 9'd2;
      exp_st = (k < 2) ? 3'd0 : 3'd4;
      check_eq($sformatf("step%0d_nwr", k), wr_n - base, exp_w);
      check_eq($sformatf("step%0d_pc", k), pc, exp_pc);
      check_eq($sformatf("step%0d_state", k), state, exp_st);
    end

    // program B: two IRMOVs, no HALT -> ends on pc==prog_len
    prog_w[0] = 32'h1001_9234;
    prog_w[1] = 32'h1003_8001;
    load_words(2, 1'b1);
    check_eq("B_prog_len", prog_len, 10'd2);
    base = wr_n;
    start = 1'b1;
    wait_halted("B_halted", 30);
    start = 1'b0;
    check_eq("B_nwr", wr_n - base, 2);
    check_eq("B_w0", {wr_dst[base], wr_dat[base]}, {3'd3, 32'h0000_1234});
    check_eq("B_w1", {wr_dst[base+1], wr_dat[base+1]}, {3'd7, 32'h0000_0001});
    check_eq("B_pc", pc, 9'd2);

    // overflow: 512 words without load_last
    for (int i = 0; i < 512; i++) prog_w[i] = 32'hA500_0000 + i;
    load_words(512, 1'b0);
    check_eq("ovf_flag", {63'd0, load_ovf}, 64'd1);
    check_eq("ovf_prog_len", prog_len, 10'd512);
    check_eq("ovf_ready_low", {63'd0, load_ready}, 64'd0);
    check_eq("ovf_state", state, 3'd0);
    check_eq("ovf_mem511", mem[511], 32'hA500_01FF);
    check_eq("ovf_mem0", mem[0], 32'hA500_0000);

    // async reset in EXEC of IRMOV r4,0xABC
    prog_w[0] = 32'h1002_0ABC;
    load_words(1, 1'b1);
    start = 1'b1;
    begin
      int k;
      k = 0;
      while (state != 3'd3 && k < 10) begin
        @(negedge clock);
        k++;
      end
    end
    check_eq("pre_rst_exec", state, 3'd3);
    check_eq("pre_rst_wen", {63'd0, rf_wen}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_state", state, 3'd0);
    check_eq("arst_pc", pc, 9'd0);
    check_eq("arst_wen", {63'd0, rf_wen}, 64'd0);
    check_eq("arst_ovf", {63'd0, load_ovf}, 64'd0);
    @(posedge clock);
    #1;
    check_eq("arst_no_write", rf_m[4], 32'd0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    check_eq("strobe_outside_state", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle run controller in front of the instruction RAM and register file of the task processor.
- Owns the single RAM port. Loads a program from a host word stream, then sequences FETCH/EXEC per instruction.
- Generates the PC and the register-write strobe. Supports run, single-step and halt.
- Replaces the free-running `pc <= pc + 1` scheme, so writeback happens only when a fetched word is valid.

Parameters:
- ADDR_W, 9, RAM address width (DEPTH = 2**ADDR_W words).
- DATA_W, 32, instruction/data word width.
- OP_HALT, 4'h0, icode that stops execution (any ifun).
- OP_IRMOV, 4'h1, icode that writes zero-extended valC to rd.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  host load word valid.
- load_data  in  DATA_W  host load word.
- load_last  in  1  marks final word of program (qualified by load_valid).
- load_ready  out  1  sequencer accepts a load word this cycle.
- start  in  1  level: run continuously while high.
- step  in  1  one-cycle pulse: execute exactly one instruction.
- ram_addr  out  ADDR_W  RAM address.
- ram_wEn  out  1  RAM write enable.
- ram_wDat  out  DATA_W  RAM write data.
- ram_rEn  out  1  RAM read enable.
- ram_rDat  in  DATA_W  RAM read data, registered, valid 1 cycle after rEn.
- rf_wen  out  1  register-file write strobe.
- rf_dst  out  3  destination register.
- rf_wdata  out  DATA_W  write data.
- pc  out  ADDR_W  current program counter.
- prog_len  out  ADDR_W+1  number of words loaded.
- halted  out  1  HALT state reached.
- load_ovf  out  1  sticky: load filled RAM without load_last.
- state  out  3  FSM state (debug).

Behaviour:
- Reset (async): state=IDLE, pc=0, load_ptr=0, prog_len=0, halted=0, load_ovf=0. All strobes (ram_wEn, ram_rEn, rf_wen) are 0; load_ready=0.
- Reset mid-load or mid-run aborts immediately. RAM contents are not cleared.
- States, encoded IDLE=0, LOAD=1, FETCH=2, EXEC=3, HALT=4:
  - IDLE: load_valid has priority → LOAD (that word is not yet accepted). Else start or step → FETCH. step is latched as single_step=1.
  - LOAD: load_ready=1. On load_valid, in the same cycle: ram_addr=load_ptr, ram_wEn=1, ram_wDat=load_data; load_ptr++. The load ends when load_last=1 or load_ptr==DEPTH-1:
    - prog_len=load_ptr+1; pc=0; load_ptr=0; halted=0; → IDLE.
    - If the load ended at DEPTH-1 without load_last, set load_ovf.
    - start and step are ignored in LOAD.
  - FETCH: ram_addr=pc, ram_rEn=1 → EXEC.
  - EXEC: decode ram_rDat using icode[31:28], rd[17:15], valC[14:0].
    - icode==OP_HALT → HALT; pc unchanged; no rf_wen.
    - icode==OP_IRMOV: rf_wen=1 for exactly this cycle; rf_dst=rd; rf_wdata={17'b0,valC}.
    - Other icodes: no write (NOP).
    - Non-halt: pc<=pc+1. Then, in priority order:
      1. pc+1 == prog_len → HALT (end of program).
      2. single_step → IDLE, clear single_step.
      3. start==0 → IDLE.
      4. Otherwise → FETCH.
  - HALT: halted=1; no RAM reads. Leaves HALT only on a new load (load_valid → LOAD) or reset. start and step are ignored.
- Throughput: 2 cycles per instruction. rf_wen asserts in the cycle after FETCH. A write is visible at the register-file outputs on the following edge.
- prog_len==0, i.e. no program loaded: start and step are ignored; stay IDLE.
- The pc wrap at DEPTH cannot occur, because prog_len ≤ DEPTH stops execution first.
- step and start both asserted in IDLE: step wins, so only one instruction executes.
- step pulse outside IDLE is ignored; it is not queued.
- ram_wEn is never asserted outside LOAD. ram_rEn is never asserted outside FETCH.

Decomposition:
- Shared package `proc_pkg`:
  - State encoding constants.
  - OP_HALT and OP_IRMOV icodes.
  - Instruction field bit positions: icode 31:28, ifun 27:24, rA 23:21, rB 20:18, rd 17:15, valC 14:0.
- One natural sub-module, `instr_decode`: combinational field split plus the is_halt/is_irmov flags. It is reused by the processor top for debug outputs.
- All other logic (FSM, pc, load_ptr) stays in `exec_sequencer`.

Test Plan:
- Load 3 words: {IRMOV rd=1 valC=5; IRMOV rd=2 valC=0x7FFF; HALT}, last on word 2.
  - Expect RAM[0..2] written, prog_len=3, load_ovf=0.
- After that load, start=1.
  - Expect rf_wen pulses with (1, 0x5) and then (2, 0x00007FFF), two cycles apart.
  - Then halted=1, pc=2, and no further ram_rEn.
- Same program, three step pulses spaced 5 cycles apart.
  - Expect exactly one rf_wen per step, with state back in IDLE between steps.
  - The third step reaches HALT.
- Load 2 IRMOVs with no HALT, then start.
  - Expect both writes, then HALT on pc==prog_len=2.
- Stream 512 words without load_last.
  - Expect load_ovf=1 and prog_len=512.
  - Expect load_ready deasserted after the 512th accept.
- Assert reset during EXEC of an IRMOV (async, mid-cycle).
  - Expect immediate state=IDLE, pc=0, rf_wen=0, with no write at the next edge.
